// File: rtl/lbg_mean_split_pkg.sv
// Shared types and helpers for the LBG mean/split codebook seeder.
package lbg_mean_split_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_DRAIN,
    S_DIV,
    S_WR_P,
    S_WR_M,
    S_FIN
  } state_t;

  // Sum of up to 2^FRAME_W samples of DATA_W bits cannot overflow this width.
  function automatic int acc_width(input int data_w, input int frame_w);
    return data_w + frame_w;
  endfunction

  function automatic logic signed [31:0] saturate(input logic signed [31:0] v, input int w);
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    hi = (32'sd1 <<< (w - 1)) - 32'sd1;
    lo = -hi - 32'sd1;
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/lbg_sdiv.sv
// Sequential signed restoring divider: signed numerator / unsigned nonzero denominator,
// quotient truncated toward zero; rdy pulses NUM_W+1 cycles after start.
module lbg_sdiv #(
  parameter int NUM_W = 23,
  parameter int DEN_W = 9
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic signed [NUM_W-1:0] num,
  input  logic [DEN_W-1:0]        den,
  output logic                    rdy,
  output logic signed [NUM_W-1:0] quo
);

  localparam int CNT_W = $clog2(NUM_W + 1);

  logic             run;
  logic [CNT_W-1:0] cnt;
  logic             neg;
  logic [NUM_W-1:0] q;
  logic [DEN_W:0]   rem;
  logic [DEN_W-1:0] dvs;
  logic [DEN_W:0]   trial;
  logic             ge;

  // rem stays below dvs, so its top bit is always zero before the shift.
  always_comb begin
    trial = {rem[DEN_W-1:0], q[NUM_W-1]};
    ge    = (trial >= {1'b0, dvs});
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      run <= 1'b0;
      cnt <= '0;
      neg <= 1'b0;
      q   <= '0;
      rem <= '0;
      dvs <= '0;
    end else if (start) begin
      run <= 1'b1;
      cnt <= CNT_W'(NUM_W);
      neg <= num[NUM_W-1];
      q   <= num[NUM_W-1] ? NUM_W'(-num) : NUM_W'(num);
      rem <= '0;
      dvs <= den;
    end else if (run) begin
      if (cnt != '0) begin
        q   <= {q[NUM_W-2:0], ge};
        rem <= ge ? (trial - {1'b0, dvs}) : trial;
        cnt <= cnt - CNT_W'(1);
      end else begin
        run <= 1'b0;
      end
    end
  end

  assign rdy = run && (cnt == '0);
  assign quo = neg ? -$signed(q) : $signed(q);

endmodule

// File: rtl/lbg_mean_split.sv
// Per-dimension mean of N feature frames, optionally split into a +/- eps codeword pair
// for LBG codebook initialisation; one dimension at a time, sequential divide.
module lbg_mean_split
  import lbg_mean_split_pkg::*;
#(
  parameter int DIM       = 13,
  parameter int DATA_W    = 14,
  parameter int FRAME_W   = 9,
  parameter int ADDR_W    = 13,
  parameter int EPS_SHIFT = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       split_en,
  input  logic [ADDR_W-1:0]          base_addr,
  input  logic [FRAME_W-1:0]         frames,
  output logic [ADDR_W-1:0]          feat_addr,
  output logic                       feat_rd,
  input  logic [DATA_W-1:0]          feat_data,
  output logic                       cb_wr_en,
  output logic [$clog2(2*DIM)-1:0]   cb_wr_addr,
  output logic [DATA_W-1:0]          cb_wr_data,
  output logic                       busy,
  output logic                       done,
  output logic                       err
);

  localparam int ACC_W = acc_width(DATA_W, FRAME_W);
  localparam int CB_AW = $clog2(2 * DIM);
  localparam int DW    = (DIM > 1) ? $clog2(DIM) : 1;
  localparam logic [DW-1:0] D_LAST = DW'(DIM - 1);

  state_t state, state_nxt;

  logic                     split_q, err_q, rd_vld, next_dim, div_start, div_rdy;
  logic [ADDR_W-1:0]        base_q, rd_addr;
  logic [FRAME_W-1:0]       frames_q, f;
  logic [DW-1:0]            d;
  logic signed [ACC_W-1:0]  acc, acc_nxt, quo;
  logic signed [DATA_W-1:0] mean, plus_s, minus_s;
  logic [DATA_W:0]          mag, eps;
  logic signed [DATA_W+1:0] plus_w, minus_w;

  // The divider sees the sum including the sample landing in DRAIN.
  assign acc_nxt = rd_vld ? (acc + ACC_W'($signed(feat_data))) : acc;

  lbg_sdiv #(.NUM_W(ACC_W), .DEN_W(FRAME_W)) u_div (
    .clk   (clk),
    .rst   (rst),
    .start (div_start),
    .num   (acc_nxt),
    .den   (frames_q),
    .rdy   (div_rdy),
    .quo   (quo)
  );

  always_comb begin
    mag     = mean[DATA_W-1] ? -{mean[DATA_W-1], mean} : {mean[DATA_W-1], mean};
    eps     = mag >> EPS_SHIFT;
    plus_w  = (DATA_W+2)'(mean) + $signed({1'b0, eps});
    minus_w = (DATA_W+2)'(mean) - $signed({1'b0, eps});
    plus_s  = DATA_W'(saturate(32'(plus_w), DATA_W));
    minus_s = DATA_W'(saturate(32'(minus_w), DATA_W));
  end

  always_comb begin
    state_nxt  = state;
    feat_rd    = 1'b0;
    div_start  = 1'b0;
    next_dim   = 1'b0;
    cb_wr_en   = 1'b0;
    cb_wr_addr = '0;
    cb_wr_data = '0;
    done       = 1'b0;
    err        = 1'b0;
    case (state)
      S_IDLE:  if (start) state_nxt = (frames == '0) ? S_FIN : S_READ;
      S_READ: begin
        feat_rd = 1'b1;
        if (f == frames_q - FRAME_W'(1)) state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        div_start = 1'b1;
        state_nxt = S_DIV;
      end
      S_DIV:   if (div_rdy) state_nxt = S_WR_P;
      S_WR_P: begin
        cb_wr_en = 1'b1;
        if (split_q) begin
          cb_wr_addr = CB_AW'({d, 1'b0});
          cb_wr_data = plus_s;
          state_nxt  = S_WR_M;
        end else begin
          cb_wr_addr = CB_AW'(d);
          cb_wr_data = mean;
          next_dim   = (d != D_LAST);
          state_nxt  = (d == D_LAST) ? S_FIN : S_READ;
        end
      end
      S_WR_M: begin
        cb_wr_en   = 1'b1;
        cb_wr_addr = CB_AW'({d, 1'b1});
        cb_wr_data = minus_s;
        next_dim   = (d != D_LAST);
        state_nxt  = (d == D_LAST) ? S_FIN : S_READ;
      end
      S_FIN: begin
        done      = 1'b1;
        err       = err_q;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      split_q  <= 1'b0;
      err_q    <= 1'b0;
      base_q   <= '0;
      frames_q <= '0;
      rd_addr  <= '0;
      rd_vld   <= 1'b0;
      f        <= '0;
      d        <= '0;
      acc      <= '0;
      mean     <= '0;
    end else begin
      rd_vld <= feat_rd;
      if (state == S_IDLE && start) begin
        split_q  <= split_en;
        err_q    <= (frames == '0);
        base_q   <= base_addr;
        frames_q <= frames;
        rd_addr  <= base_addr;
        f        <= '0;
        d        <= '0;
        acc      <= '0;
      end else if (next_dim) begin
        rd_addr <= base_q + ADDR_W'(d) + ADDR_W'(1);
        f       <= '0;
        d       <= d + DW'(1);
        acc     <= '0;
      end else begin
        acc <= acc_nxt;
        if (state == S_READ) begin
          f       <= f + FRAME_W'(1);
          rd_addr <= rd_addr + ADDR_W'(DIM);
        end
        if (state == S_DIV && div_rdy) mean <= DATA_W'(quo);
      end
    end
  end

  assign feat_addr = (state == S_READ) ? rd_addr : '0;
  assign busy      = (state != S_IDLE);

endmodule

// File: doc/lbg_mean_split.md
LBG_MEAN_SPLIT -- requirements
Module: lbg_mean_split

Interface
REQ-001 SHALL have parameter DIM, default 13, vector dimension (coefficients per frame).
REQ-002 SHALL have parameter DATA_W, default 14, signed MFCC sample width.
REQ-003 SHALL have parameter FRAME_W, default 9, frame-count width.
REQ-004 SHALL have parameter ADDR_W, default 13, feature-memory address width.
REQ-005 SHALL have parameter EPS_SHIFT, default 3, split perturbation = |mean| >> EPS_SHIFT.
REQ-006 SHALL have port clk  input  1  sole clock; all logic on the rising edge.
REQ-007 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-008 SHALL have port start  input  1  single-cycle request; sampled only in IDLE.
REQ-009 SHALL have port split_en  input  1  captured at start; 1 = emit split pair, 0 = emit mean only.
REQ-010 SHALL have port base_addr  input  ADDR_W  address of frame 0 coefficient 0; captured at start.
REQ-011 SHALL have port frames  input  FRAME_W  frame count N; captured at start.
REQ-012 SHALL have port feat_addr  output  ADDR_W  feature-memory read address.
REQ-013 SHALL have port feat_rd  output  1  read strobe; feat_data is valid exactly 1 cycle later.
REQ-014 SHALL have port feat_data  input  DATA_W  signed feature sample.
REQ-015 SHALL have ports cb_wr_en (output, 1), cb_wr_addr (output, clog2(2*DIM)) and cb_wr_data (output, DATA_W): codebook write port.
REQ-016 SHALL have ports busy, done and err, each output 1: busy high outside IDLE; done and err are 1-cycle pulses.

Function
REQ-017 SHALL implement the FSM states IDLE, READ, DRAIN, DIV, WR_P, WR_M and FIN.
REQ-018 In IDLE, start=1 SHALL capture inputs, clear dimension index d to 0 and the accumulator, and enter READ; if frames==0, it SHALL enter FIN with err instead.
REQ-019 READ SHALL assert feat_rd for exactly N consecutive cycles, with addresses base + f*DIM + d for f=0..N-1, computed mod 2^ADDR_W.
REQ-020 The accumulator SHALL be ACC_W = DATA_W+FRAME_W bits signed, cleared per dimension, and add each sign-extended feat_data in its valid cycle; it cannot overflow.
REQ-021 DRAIN SHALL last 1 cycle to absorb the final sample, then pulse the divider start and enter DIV.
REQ-022 The divide SHALL be signed: accumulator / N, quotient truncated toward zero, then truncated to DATA_W (always in range).
REQ-023 After the divider ready pulse, with split_en=0: WR_P SHALL write mean to address d for 1 cycle, and WR_M SHALL be skipped.
REQ-024 After the divider ready pulse, with split_en=1: WR_P SHALL write mean+eps to address 2d, then WR_M SHALL write mean-eps to address 2d+1 on the next cycle.
REQ-025 eps SHALL equal |mean| >> EPS_SHIFT, and split results SHALL saturate to the DATA_W signed range.
REQ-026 After the last write of dimension d: if d<DIM-1, the block SHALL increment d and return to READ; otherwise it SHALL enter FIN.
REQ-027 FIN SHALL last 1 cycle: done=1, err=1 only if frames==0, then IDLE; busy SHALL fall in the cycle after FIN.
REQ-028 Per-dimension latency SHALL be N + 1 + DIV_LAT + (split_en ? 2 : 1) cycles, where DIV_LAT = ACC_W + 1.
REQ-029 start while busy SHALL be ignored, with no effect on the run in progress.
REQ-030 cb_wr_en SHALL be high only in WR_P/WR_M, and feat_rd only in READ.

Reset
REQ-031 rst=1 SHALL force IDLE in the same clock edge, from any state including mid-run.
REQ-032 rst=1 SHALL clear the accumulator, d and the divider.
REQ-033 After reset, all outputs SHALL be 0, and no done or write SHALL be issued for an aborted run.

Structure
REQ-034 A shared package SHALL hold the FSM state enum, the ACC_W derivation and the saturate helper function.
REQ-035 A single sub-module lbg_sdiv (sequential signed restoring divider, start/rdy handshake, DIV_LAT cycles) SHALL be instantiated once; mean and split arithmetic stay in the parent.

Verification
REQ-036 The bench SHALL check: DIM=13, N=4, all samples 100, split_en=1 -> 26 writes, even addresses 112, odd addresses 88, then done.
REQ-037 The bench SHALL check: N=2, samples -7 and -8, split_en=0 -> mean -7 (truncation toward zero), 13 writes at addresses 0..12.
REQ-038 The bench SHALL check: frames=0 -> done and err together in one pulse, no feat_rd, no cb_wr_en.
REQ-039 The bench SHALL check: all samples 8191, split_en=1 -> plus saturates to 8191, minus equals 7168.
REQ-040 The bench SHALL check: start pulsed again mid-run -> ignored, and the write sequence and count are unchanged.
REQ-041 The bench SHALL check: rst mid-DIV -> IDLE next cycle, no further writes, no done; a fresh start then completes normally.
